// File: rtl/demux32b_stream_if.sv
// demux32b_stream_if: input stream, select and four output channels of the 1-to-4 demux; count_ exists only with DEMUX32B_STREAM_COUNT_EN
interface demux32b_stream_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] _input;
  logic in_valid;
  logic [1:0] sel;
  logic in_ready;
  logic [WIDTH-1:0] output0_;
  logic [WIDTH-1:0] output1_;
  logic [WIDTH-1:0] output2_;
  logic [WIDTH-1:0] output3_;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
`ifdef DEMUX32B_STREAM_COUNT_EN
  logic [63:0] count_;
  modport slave (input _input, in_valid, sel, out_ready, output in_ready, output0_, output1_, output2_, output3_, out_valid, count_);
  modport master (output _input, in_valid, sel, out_ready, input in_ready, output0_, output1_, output2_, output3_, out_valid, count_);
`else
  modport slave (input _input, in_valid, sel, out_ready, output in_ready, output0_, output1_, output2_, output3_, out_valid);
  modport master (output _input, in_valid, sel, out_ready, input in_ready, output0_, output1_, output2_, output3_, out_valid);
`endif
endinterface

// File: rtl/demux32b_stream.sv
// demux32b_stream: 1-to-4 valid/ready demux with one register slot per channel; DEMUX32B_STREAM_COUNT_EN adds per-channel drain counters
module demux32b_stream #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  demux32b_stream_if.slave b
);
  logic [WIDTH-1:0] slot_data [4];
  logic [3:0] full;
  logic [3:0] drain;
  logic [3:0] acc;
  assign b.in_ready = !full[b.sel] | b.out_ready[b.sel];
  assign drain = full & b.out_ready;
  assign acc = (b.in_valid & b.in_ready) ? 4'b0001 << b.sel : 4'b0000;
  assign b.out_valid = full;
  assign b.output0_ = slot_data[0];
  assign b.output1_ = slot_data[1];
  assign b.output2_ = slot_data[2];
  assign b.output3_ = slot_data[3];
  // an accept into a draining slot keeps it full, so each channel sustains one word per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      for (int i = 0; i < 4; i++) slot_data[i] <= '0;
    end else begin
      full <= (full & ~drain) | acc;
      for (int i = 0; i < 4; i++) if (acc[i]) slot_data[i] <= b._input;
    end
  end
`ifdef DEMUX32B_STREAM_COUNT_EN
  logic [15:0] cnt [4];
  assign b.count_ = {cnt[3], cnt[2], cnt[1], cnt[0]};
  // drain counters wrap naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 4; i++) cnt[i] <= '0;
    else for (int i = 0; i < 4; i++) if (drain[i]) cnt[i] <= cnt[i] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_demux32b_stream.sv
// tb_demux32b_stream: directed vectors for demux32b_stream; define DEMUX32B_STREAM_COUNT_EN to also exercise the counters
module tb_demux32b_stream;
  logic clk = 0;
  logic reset = 1;
  int n_cmp = 0;
  int n_bad = 0;
  demux32b_stream_if #(.WIDTH(32)) b ();
  demux32b_stream #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] s, input logic [31:0] d);
    b.in_valid = 1;
    b.sel = s;
    b._input = d;
    tick();
    b.in_valid = 0;
  endtask
  initial begin
    b.in_valid = 0;
    b.sel = 0;
    b._input = 0;
    b.out_ready = 0;
    tick();
    tick();
    reset = 0;
    chk("rst_valid", 64'(b.out_valid), 64'h0);
    chk("rst_out0", 64'(b.output0_), 64'h0);
    chk("rst_out3", 64'(b.output3_), 64'h0);
    chk("rst_ready", 64'(b.in_ready), 64'h1);
    push(2, 32'hDEADBEEF);
    chk("t1_valid", 64'(b.out_valid), 64'h4);
    chk("t1_out2", 64'(b.output2_), 64'hDEADBEEF);
    b.sel = 2;
    #1 chk("t1_ready_sel2", 64'(b.in_ready), 64'h0);
    b.sel = 0;
    #1 chk("t1_ready_sel0", 64'(b.in_ready), 64'h1);
    b.out_ready = 4'b0100;
    b.sel = 2;
    b._input = 32'h5;
    b.in_valid = 1;
    #1 chk("t2_ready", 64'(b.in_ready), 64'h1);
    tick();
    chk("t2_out2", 64'(b.output2_), 64'h5);
    chk("t2_valid", 64'(b.out_valid), 64'h4);
    for (int k = 6; k < 9; k++) begin
      b._input = 32'(k);
      tick();
      chk("t2_b2b", 64'(b.output2_), 64'(k));
    end
    b.in_valid = 0;
    tick();
    chk("t2_drained", 64'(b.out_valid), 64'h0);
    b.out_ready = 0;
    push(1, 32'hAAAA);
    b.out_ready = 4'b1000;
    for (int k = 1; k < 4; k++) begin
      push(3, 32'(k));
      chk("t3_out3", 64'(b.output3_), 64'(k));
      chk("t3_out1", 64'(b.output1_), 64'hAAAA);
      chk("t3_valid", 64'(b.out_valid), 64'hA);
    end
    tick();
    chk("t3_valid_end", 64'(b.out_valid), 64'h2);
    b.out_ready = 0;
    push(0, 32'h10);
    b.out_ready = 4'b0010;
    push(1, 32'h11);
    b.out_ready = 0;
    push(2, 32'h12);
    push(3, 32'h13);
    chk("t4_valid_full", 64'(b.out_valid), 64'hF);
    chk("t4_out0", 64'(b.output0_), 64'h10);
    chk("t4_out1", 64'(b.output1_), 64'h11);
    chk("t4_out2", 64'(b.output2_), 64'h12);
    chk("t4_out3", 64'(b.output3_), 64'h13);
    b.out_ready = 4'b1111;
    tick();
    chk("t4_valid_empty", 64'(b.out_valid), 64'h0);
    b.out_ready = 0;
    for (int k = 0; k < 4; k++) push(2'(k), 32'h20 + 32'(k));
    chk("t5_prefill", 64'(b.out_valid), 64'hF);
    b.in_valid = 1;
    b.sel = 0;
    b._input = 32'h99;
    reset = 1;
    tick();
    reset = 0;
    b.in_valid = 0;
    chk("t5_valid", 64'(b.out_valid), 64'h0);
    chk("t5_out0", 64'(b.output0_), 64'h0);
    chk("t5_out2", 64'(b.output2_), 64'h0);
    chk("t5_ready", 64'(b.in_ready), 64'h1);
    tick();
    chk("t5_dropped", 64'(b.out_valid), 64'h0);
`ifdef DEMUX32B_STREAM_COUNT_EN
    chk("t5_count", b.count_, 64'h0);
    b.out_ready = 4'b0001;
    b.sel = 0;
    b.in_valid = 1;
    for (int k = 0; k < 65536; k++) begin
      b._input = 32'(k);
      tick();
    end
    b.in_valid = 0;
    chk("t6_cnt_ffff", 64'(b.count_[15:0]), 64'hFFFF);
    tick();
    chk("t6_cnt_wrap", 64'(b.count_[15:0]), 64'h0);
    chk("t6_cnt_others", 64'(b.count_[63:16]), 64'h0);
    b.out_ready = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
